// File: rtl/sr_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: RISC-V M funct3 codes,
// FSM state codes and the operand-signedness decode.
package sr_muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] MD_IDLE  = 2'd0;
  localparam logic [1:0] MD_CALC  = 2'd1;
  localparam logic [1:0] MD_FIXUP = 2'd2;
  localparam logic [1:0] MD_DONE  = 2'd3;

  // srcA is signed for MUL/MULH/MULHSU/DIV/REM; srcB for MUL/MULH/DIV/REM.
  function automatic logic a_is_signed(input logic [2:0] op);
    return op[2] ? !op[0] : (op[1:0] != 2'b11);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] op);
    return op[2] ? !op[0] : !op[1];
  endfunction

endpackage

// File: rtl/sr_muldiv_step.sv
// One radix-2 step on the {hi, lo} working pair: shift-add (multiply, mode_i=0)
// or shift-subtract-restore (divide, mode_i=1).
module sr_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            mode_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // NOTE: every output and temporary is assigned on every path, so no latch is inferred.
  always_comb begin
    sum     = {1'b0, hi_i} + {1'b0, (lo_i[0] ? b_i : {XLEN{1'b0}})};
    shifted = {hi_i, lo_i[XLEN-1]};
    diff    = shifted - {1'b0, b_i};
    if (mode_i) begin
      // Partial remainder stays below the divisor, so bit XLEN of diff is a pure borrow.
      if (!diff[XLEN]) begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = shifted[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/sr_muldiv.sv
// Iterative RISC-V M-extension unit: FSM, step counter, magnitude operands,
// divide-by-zero/overflow fast path and the sign/half-select FIXUP cycle.
module sr_muldiv
  import sr_muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N) + 1;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] m_q, m_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;

  assign sa       = a_is_signed(op) & srcA[XLEN-1];
  assign sb       = b_is_signed(op) & srcB[XLEN-1];
  assign mag_a    = sa ? -srcA : srcA;
  assign mag_b    = sb ? -srcB : srcB;
  assign div_zero = op[2] && (srcB == '0);
  assign div_ovf  = op[2] && !op[0] && (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
  assign fast_res = div_zero ? (op[1] ? srcA : '1) : (op[1] ? '0 : srcA);

  logic [XLEN-1:0] hi_c [0:UNROLL];
  logic [XLEN-1:0] lo_c [0:UNROLL];

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    sr_muldiv_step #(.XLEN(XLEN)) u_step (
      .mode_i (op_q[2]),
      .b_i    (m_q),
      .hi_i   (hi_c[g]),
      .lo_i   (lo_c[g]),
      .hi_o   (hi_c[g+1]),
      .lo_o   (lo_c[g+1])
    );
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  assign prod_s  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_s   = neg_q ? -lo_q : lo_q;
  assign rem_s   = rneg_q ? -hi_q : hi_q;
  assign fix_res = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                           : ((op_q == MD_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      MD_IDLE: begin
        if (in_valid && !kill) begin
          op_d   = op;
          cnt_d  = '0;
          hi_d   = '0;
          neg_d  = sa ^ sb;
          rneg_d = sa;
          // Divide iterates on the dividend in lo; multiply iterates on the multiplier.
          m_d    = op[2] ? mag_b : mag_a;
          lo_d   = op[2] ? mag_a : mag_b;
          if (div_zero || div_ovf) begin
            result_d = fast_res;
            state_d  = MD_DONE;
          end else begin
            state_d  = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        hi_d  = hi_c[UNROLL];
        lo_d  = lo_c[UNROLL];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = MD_FIXUP;
      end
      MD_FIXUP: begin
        result_d = fix_res;
        state_d  = MD_DONE;
      end
      default: begin
        if (out_ready) state_d = MD_IDLE;
      end
    endcase
    if (kill) state_d = MD_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == MD_IDLE);
  assign busy      = (state_q != MD_IDLE);
  assign out_valid = (state_q == MD_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_sr_muldiv.sv
// Self-checking bench: UNROLL=1 and UNROLL=4 instances share stimulus and are checked
// against an arithmetic reference model for result and latency.
module tb_sr_muldiv;
  import sr_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        kill = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;

  logic        rdy1, ov1, busy1, rdy4, ov4, busy4;
  logic [31:0] res1, res4;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  sr_muldiv #(.XLEN(32), .UNROLL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .op(op),
    .srcA(src_a), .srcB(src_b), .kill(kill), .out_valid(ov1), .out_ready(out_ready),
    .result(res1), .busy(busy1)
  );

  sr_muldiv #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .op(op),
    .srcA(src_a), .srcB(src_b), .kill(kill), .out_valid(ov4), .out_ready(out_ready),
    .result(res4), .busy(busy4)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    case (o)
      MD_MUL:    begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      MD_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
      MD_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = p[63:32]; end
      MD_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      MD_DIV:    if (b == 0) r = 32'hFFFFFFFF;
                 else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                 else r = $signed(a) / $signed(b);
      MD_DIVU:   r = (b == 0) ? 32'hFFFFFFFF : a / b;
      MD_REM:    if (b == 0) r = a;
                 else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                 else r = $signed(a) % $signed(b);
      default:   r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input int unroll);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    return 32 / unroll + 2;
  endfunction

  // Issue one request (entered just after a negedge) and wait for both results.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] r1, output logic [31:0] r4,
                     output int l1, output int l4, output int rdy_bad);
    int edges;
    in_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    edges = 1;
    #1;
    in_valid = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    l1 = -1; l4 = -1; rdy_bad = 0; r1 = 'x; r4 = 'x;
    for (int i = 0; i < 100 && (l1 < 0 || l4 < 0); i++) begin
      @(negedge clk);
      if (l1 < 0) begin
        if (rdy1 || !busy1) rdy_bad++;
        if (ov1) begin l1 = edges; r1 = res1; end
      end
      if (l4 < 0) begin
        if (rdy4 || !busy4) rdy_bad++;
        if (ov4) begin l4 = edges; r4 = res4; end
      end
      if (l1 < 0 || l4 < 0) begin
        @(posedge clk);
        edges++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_txn(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] r1, r4;
    int l1, l4, bad;
    run(o, a, b, r1, r4, l1, l4, bad);
    check({name, "_res_u1"}, r1, exp);
    check({name, "_res_u4"}, r4, exp);
    check({name, "_lat_u1"}, 32'(l1), 32'(exp_lat(o, a, b, 1)));
    check({name, "_lat_u4"}, 32'(l4), 32'(exp_lat(o, a, b, 4)));
    check({name, "_busy_notready"}, 32'(bad), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  ro;
    logic        seen;

    vecs[0]  = '{MD_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{MD_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
    vecs[5]  = '{MD_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
    vecs[6]  = '{MD_DIVU,   32'd100,      32'd7,        32'd14};
    vecs[7]  = '{MD_REMU,   32'd100,      32'd7,        32'd2};
    vecs[8]  = '{MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{MD_REM,    32'd5,        32'd0,        32'd5};
    vecs[10] = '{MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[11] = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[12] = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[13] = '{MD_REMU,   32'd5,        32'd0,        32'd5};

    repeat (2) @(negedge clk);
    check("reset_state_u1", {28'b0, rdy1, busy1, ov1, 1'b0}, {28'b0, 4'b1000});
    check("reset_state_u4", {28'b0, rdy4, busy4, ov4, 1'b0}, {28'b0, 4'b1000});
    check("reset_result", res1 | res4, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      do_txn($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
    end

    // Back-pressure: hold DONE with a competing request pending.
    out_ready = 1'b0;
    in_valid = 1'b1; op = MD_MUL; src_a = 32'd7; src_b = 32'hFFFFFFFD;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = ov1 && ov4;
    end
    check("bp_reached_done", {31'b0, seen}, 32'd1);
    in_valid = 1'b1; op = MD_DIVU; src_a = 32'd100; src_b = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_flags", {28'b0, ov1, ov4, rdy1, rdy4}, {28'b0, 4'b1100});
      check("bp_hold_res_u1", res1, 32'hFFFFFFEB);
      check("bp_hold_res_u4", res4, 32'hFFFFFFEB);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", {28'b0, ov1, ov4, rdy1, rdy4}, {28'b0, 4'b0011});
    do_txn("b2b_divu", MD_DIVU, 32'd100, 32'd7, 32'd14);
    do_txn("b2b_mulhu", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);

    // kill during CALC.
    in_valid = 1'b1; op = MD_DIV; src_a = 32'd1000; src_b = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check("kill_idle", {28'b0, busy1, busy4, ov1, ov4}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov1 || ov4) seen = 1'b1;
    end
    check("kill_no_valid", {31'b0, seen}, 32'd0);
    do_txn("after_kill", MD_DIVU, 32'd9, 32'd3, 32'd3);

    // kill together with in_valid in IDLE drops the request.
    in_valid = 1'b1; kill = 1'b1; op = MD_DIVU; src_a = 32'd5; src_b = 32'd0;
    @(posedge clk);
    #1 begin in_valid = 1'b0; kill = 1'b0; end
    @(negedge clk);
    check("kill_accept_dropped", {28'b0, busy1, busy4, ov1, ov4}, 32'd0);

    // Asynchronous reset mid-CALC.
    in_valid = 1'b1; op = MD_MUL; src_a = 32'd12345; src_b = 32'd678;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", {30'b0, busy1, busy4}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_flags", {28'b0, busy1, busy4, ov1, ov4}, 32'd0);
    check("async_reset_ready", {30'b0, rdy1, rdy4}, 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn("after_reset", MD_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
